sequencer: RTL and testbench
============================

# sequencer

Multi-cycle control unit for the basic 8-bit processor. It steps each instruction through fetch, decode and execute, driving the load/bus-enable strobes for the PC, MAR, IR, ACC, MDR and ALU, and the CS/R_NW handshake shared by the ROM and RAM. It sits beside the datapath and sees only the IR opcode and the ALU zero flag. It also provides run/pause control, a halt state and a retired-instruction counter.

## Interface
- WORD_W, 8, datapath word width
- OP_W, 3, opcode width (address width = WORD_W-OP_W)
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- run  in  1  1 = keep issuing instructions; 0 = pause at next instruction boundary
- op  in  OP_W  opcode field of IR
- z_flag  in  1  ALU zero flag from last arithmetic result
- PC_bus, load_PC, INC_PC  out  1 each  PC drive / load / increment
- load_MAR, Addr_bus, load_IR  out  1 each  MAR load, IR address-field drive, IR load
- MDR_bus, load_MDR  out  1 each  memory data register drive / load
- ACC_bus, load_ACC  out  1 each  accumulator drive / load
- alu_op  out  2  00 PASS, 01 ADD, 10 SUB (11 unused)
- CS  out  1  memory chip select
- R_NW  out  1  1 read, 0 write
- halted  out  1  HALT executed
- instr_count  out  WORD_W  retired-instruction count

## Operation
- Opcodes: LOAD 000, STORE 001, ADD 010, SUB 011, BNE 100, HALT 111; 101/110 are NOPs.
- States: PAUSE (reset state), F0, F1, F2, D0, X0, X1, HLT.
- Outputs are decoded from state (plus op_q and z_flag, listed below). Any strobe not listed is 0. R_NW is 1 except where stated. alu_op is 00 except where stated.
- PAUSE: no strobes. Go to F0 when run=1, else stay.
- F0: PC_bus, load_MAR, INC_PC, load_PC. Go to F1.
- F1: CS=1, R_NW=1 (read). Go to F2.
- F2: MDR_bus, load_IR. Go to D0.
- D0: Addr_bus, load_MAR. Register op into op_q.
  - LOAD/STORE/ADD/SUB: go to X0.
  - BNE: assert load_PC in the same cycle iff z_flag=0 (Mealy on z_flag), then END.
  - HALT: go to HLT.
  - NOP: END.
- X0:
  - LOAD/ADD/SUB (from op_q): CS=1, R_NW=1.
  - STORE: ACC_bus, load_MDR.
  - Go to X1.
- X1:
  - LOAD: MDR_bus, load_ACC, alu_op=00.
  - ADD: same with alu_op=01.
  - SUB: same with alu_op=10.
  - STORE: CS=1, R_NW=0 (write).
  - Then END.
- END (transition, not a state): instr_count += 1. Next state is F0 if run=1, else PAUSE.
- HLT: halted=1, no other strobes. Stays until reset; run is ignored. HALT does not increment instr_count.
- instr_count is WORD_W bits unsigned and wraps 2^WORD_W-1 → 0.
- run=0 mid-instruction has no effect until END. An instruction is never abandoned.
- op is sampled only in D0. Changes to op outside D0 are ignored.

## Timing
- Reset (asynchronous, any state): state=PAUSE, all strobes 0, R_NW=1, alu_op=00, halted=0, instr_count=0, op_q=0. Release takes effect on the next rising edge.
- Latency from run=1 in PAUSE: F0 strobes appear 1 cycle later.
- Cycles per instruction, counted F0 through last state:
  - LOAD/STORE/ADD/SUB: 6.
  - BNE/NOP: 4.
  - HALT: 4 to reach HLT.
- instr_count updates on the clock edge that leaves the final state of the instruction. For example, it updates on the edge out of X1 for a LOAD.
- With run held at 1, F0 of the next instruction directly follows the final state; there are no bubbles.
- CS is never asserted in two consecutive cycles within one instruction. R_NW=0 only ever coincides with CS=1 in X1 of a STORE.

## Test plan
- Reset mid-X1 of a STORE (CS=1, R_NW=0): outputs go to 0 and R_NW=1 immediately, without waiting for a clock edge; instr_count=0; state is PAUSE.
- run=1, op=LOAD then op=ADD: 12 cycles. Strobes must follow the F0..X1 sequence exactly; alu_op=00 in cycle 6 and 01 in cycle 12; instr_count goes 0→1→2.
- BNE with z_flag=0 in D0: load_PC=1 and Addr_bus=1 in the same cycle; 4 cycles total. Repeat with z_flag=1: load_PC=0 in D0.
- Drop run to 0 during X0 of a SUB: X1 completes with alu_op=10, instr_count increments, state is PAUSE and holds there. Raise run: F0 appears 1 cycle later.
- op=HALT: halted=1 from the cycle after D0. It stays 1 with run toggling, instr_count is unchanged, and only reset clears it.
- Preload the counter to 255 by running 255 NOPs (4 cycles each), then one more NOP: instr_count wraps to 0.

Source files
------------

// File: rtl/sequencer.sv
// sequencer: multi-cycle fetch/decode/execute control unit with run/pause, halt and retired-instruction counter
module sequencer #(
    parameter int WORD_W = 8,
    parameter int OP_W   = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              run,
    input  logic [OP_W-1:0]   op,
    input  logic              z_flag,
    output logic              PC_bus,
    output logic              load_PC,
    output logic              INC_PC,
    output logic              load_MAR,
    output logic              Addr_bus,
    output logic              load_IR,
    output logic              MDR_bus,
    output logic              load_MDR,
    output logic              ACC_bus,
    output logic              load_ACC,
    output logic [1:0]        alu_op,
    output logic              CS,
    output logic              R_NW,
    output logic              halted,
    output logic [WORD_W-1:0] instr_count
);
    typedef enum logic [2:0] {PAUSE, F0, F1, F2, D0, X0, X1, HLT} state_t;

    localparam logic [OP_W-1:0] OP_STORE = OP_W'(1);
    localparam logic [OP_W-1:0] OP_ADD   = OP_W'(2);
    localparam logic [OP_W-1:0] OP_SUB   = OP_W'(3);
    localparam logic [OP_W-1:0] OP_BNE   = OP_W'(4);
    localparam logic [OP_W-1:0] OP_HALT  = OP_W'(7);

    state_t          state;
    logic [OP_W-1:0] op_q;
    logic            is_mem;
    logic            is_halt;
    logic            done;
    logic            st_store;

    assign is_mem   = op <= OP_SUB;
    assign is_halt  = op == OP_HALT;
    // An instruction retires leaving X1, or leaving D0 when it has no execute phase
    assign done     = state == X1 || (state == D0 && !is_mem && !is_halt);
    assign st_store = op_q == OP_STORE;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= PAUSE;
            op_q        <= '0;
            instr_count <= '0;
        end else begin
            case (state)
                PAUSE:   state <= run ? F0 : PAUSE;
                F0:      state <= F1;
                F1:      state <= F2;
                F2:      state <= D0;
                D0: begin
                    op_q  <= op;
                    state <= is_mem ? X0 : is_halt ? HLT : run ? F0 : PAUSE;
                end
                X0:      state <= X1;
                X1:      state <= run ? F0 : PAUSE;
                default: state <= HLT;
            endcase
            if (done) instr_count <= instr_count + WORD_W'(1);
        end
    end

    // Strobes are decoded from state; the BNE load_PC in D0 follows z_flag combinationally
    assign PC_bus   = state == F0;
    assign INC_PC   = state == F0;
    assign load_PC  = state == F0 || (state == D0 && op == OP_BNE && !z_flag);
    assign load_MAR = state == F0 || state == D0;
    assign Addr_bus = state == D0;
    assign load_IR  = state == F2;
    assign MDR_bus  = state == F2 || (state == X1 && !st_store);
    assign load_ACC = state == X1 && !st_store;
    assign ACC_bus  = state == X0 && st_store;
    assign load_MDR = state == X0 && st_store;
    assign CS       = state == F1 || (state == X0 && !st_store) || (state == X1 && st_store);
    assign R_NW     = !(state == X1 && st_store);
    assign alu_op   = state != X1 ? 2'b00 : op_q == OP_ADD ? 2'b01 : op_q == OP_SUB ? 2'b10 : 2'b00;
    assign halted   = state == HLT;
endmodule

// File: tb/tb_sequencer.sv
// tb_sequencer: vector table, directed corner sequences and randomized run against an instruction-level model
module tb_sequencer;
    localparam logic [14:0] V_IDLE = 15'h0002;
    localparam logic [14:0] V_F0   = 15'h7802;
    localparam logic [14:0] V_F1   = 15'h0006;
    localparam logic [14:0] V_F2   = 15'h0302;
    localparam logic [14:0] V_D0   = 15'h0C02;
    localparam logic [14:0] V_D0B  = 15'h2C02;
    localparam logic [14:0] V_XRD  = 15'h0006;
    localparam logic [14:0] V_XST  = 15'h00C2;
    localparam logic [14:0] V_WR   = 15'h0004;
    localparam logic [14:0] V_LD   = 15'h0122;
    localparam logic [14:0] V_ADD  = 15'h012A;
    localparam logic [14:0] V_SUB  = 15'h0132;
    localparam logic [14:0] V_HLT  = 15'h0003;

    logic       clock = 0, reset = 1, run = 0, z_flag = 0;
    logic [2:0] op = 0;
    logic       PC_bus, load_PC, INC_PC, load_MAR, Addr_bus, load_IR, MDR_bus, load_MDR;
    logic       ACC_bus, load_ACC, CS, R_NW, halted;
    logic [1:0] alu_op;
    logic [7:0] instr_count;
    logic [14:0] obs;
    int n = 0, errs = 0;

    sequencer dut (
        .clock(clock), .reset(reset), .run(run), .op(op), .z_flag(z_flag),
        .PC_bus(PC_bus), .load_PC(load_PC), .INC_PC(INC_PC), .load_MAR(load_MAR),
        .Addr_bus(Addr_bus), .load_IR(load_IR), .MDR_bus(MDR_bus), .load_MDR(load_MDR),
        .ACC_bus(ACC_bus), .load_ACC(load_ACC), .alu_op(alu_op), .CS(CS), .R_NW(R_NW),
        .halted(halted), .instr_count(instr_count)
    );

    always #5 clock = ~clock;

    assign obs = {PC_bus, load_PC, INC_PC, load_MAR, Addr_bus, load_IR, MDR_bus, load_MDR,
                  ACC_bus, load_ACC, alu_op, CS, R_NW, halted};

    typedef struct {
        logic        r;
        logic [2:0]  o;
        logic        z;
        logic [14:0] ev;
        logic [7:0]  ec;
    } vec_t;

    task automatic cyc(input logic r, input logic [2:0] o, input logic z);
        @(posedge clock);
        #1;
        reset = 0;
        run = r;
        op = o;
        z_flag = z;
        @(negedge clock);
    endtask

    task automatic check(input string name, input logic [14:0] ev, input logic [7:0] ec);
        n++;
        if (obs !== ev || instr_count !== ec) begin
            errs++;
            $display("FAIL %s: got strobes=%h count=%0d, want strobes=%h count=%0d",
                     name, obs, instr_count, ev, ec);
        end
    endtask

    task automatic pulse_reset(input string name);
        #1 reset = 1;
        #1 check(name, V_IDLE, 8'd0);
    endtask

    // Strobe pattern for step s (0 = F0) of an instruction; o is the decoded opcode
    function automatic logic [14:0] mvec(input int s, input logic [2:0] o, input logic z);
        case (s)
            0: return V_F0;
            1: return V_F1;
            2: return V_F2;
            3: return (o == 3'd4 && !z) ? V_D0B : V_D0;
            4: return o == 3'd1 ? V_XST : V_XRD;
            default: return o == 3'd1 ? V_WR : o == 3'd2 ? V_ADD : o == 3'd3 ? V_SUB : V_LD;
        endcase
    endfunction

    initial begin
        vec_t tbl[23];
        logic       busy, hlt, r, z;
        logic [2:0] opl, o;
        logic [7:0] cnt;
        int         step;
        tbl = '{
            '{1'b1, 3'd0, 1'b0, V_IDLE, 8'd0}, '{1'b1, 3'd0, 1'b0, V_F0, 8'd0},
            '{1'b1, 3'd0, 1'b0, V_F1, 8'd0},   '{1'b1, 3'd0, 1'b0, V_F2, 8'd0},
            '{1'b1, 3'd0, 1'b1, V_D0, 8'd0},   '{1'b1, 3'd2, 1'b0, V_XRD, 8'd0},
            '{1'b1, 3'd2, 1'b0, V_LD, 8'd0},   '{1'b1, 3'd2, 1'b0, V_F0, 8'd1},
            '{1'b1, 3'd2, 1'b0, V_F1, 8'd1},   '{1'b1, 3'd2, 1'b0, V_F2, 8'd1},
            '{1'b1, 3'd2, 1'b0, V_D0, 8'd1},   '{1'b1, 3'd5, 1'b0, V_XRD, 8'd1},
            '{1'b0, 3'd5, 1'b0, V_ADD, 8'd1},  '{1'b1, 3'd4, 1'b0, V_IDLE, 8'd2},
            '{1'b1, 3'd4, 1'b0, V_F0, 8'd2},   '{1'b1, 3'd4, 1'b0, V_F1, 8'd2},
            '{1'b1, 3'd4, 1'b0, V_F2, 8'd2},   '{1'b1, 3'd4, 1'b0, V_D0B, 8'd2},
            '{1'b1, 3'd4, 1'b1, V_F0, 8'd3},   '{1'b1, 3'd4, 1'b1, V_F1, 8'd3},
            '{1'b1, 3'd4, 1'b1, V_F2, 8'd3},   '{1'b0, 3'd4, 1'b1, V_D0, 8'd3},
            '{1'b0, 3'd4, 1'b0, V_IDLE, 8'd4}
        };
        #2 check("reset_state", V_IDLE, 8'd0);
        for (int i = 0; i < 23; i++) begin
            cyc(tbl[i].r, tbl[i].o, tbl[i].z);
            check($sformatf("tbl%0d", i), tbl[i].ev, tbl[i].ec);
        end
        // STORE interrupted by reset while writing
        cyc(1, 1, 0); check("st_idle", V_IDLE, 8'd4);
        cyc(1, 1, 0); check("st_f0", V_F0, 8'd4);
        cyc(1, 1, 0); check("st_f1", V_F1, 8'd4);
        cyc(1, 1, 0); check("st_f2", V_F2, 8'd4);
        cyc(1, 1, 0); check("st_d0", V_D0, 8'd4);
        cyc(1, 1, 0); check("st_x0", V_XST, 8'd4);
        cyc(1, 1, 0); check("st_x1", V_WR, 8'd4);
        pulse_reset("st_async_rst");
        cyc(0, 0, 0); check("rst_hold0", V_IDLE, 8'd0);
        cyc(0, 0, 0); check("rst_hold1", V_IDLE, 8'd0);
        // SUB with run dropped during X0
        cyc(1, 3, 0); check("sub_idle", V_IDLE, 8'd0);
        cyc(1, 3, 0); check("sub_f0", V_F0, 8'd0);
        cyc(1, 3, 0); check("sub_f1", V_F1, 8'd0);
        cyc(1, 3, 0); check("sub_f2", V_F2, 8'd0);
        cyc(1, 3, 0); check("sub_d0", V_D0, 8'd0);
        cyc(0, 3, 0); check("sub_x0", V_XRD, 8'd0);
        cyc(0, 3, 0); check("sub_x1", V_SUB, 8'd0);
        cyc(0, 3, 0); check("sub_pause0", V_IDLE, 8'd1);
        cyc(0, 3, 0); check("sub_pause1", V_IDLE, 8'd1);
        cyc(1, 7, 0); check("resume_idle", V_IDLE, 8'd1);
        // HALT
        cyc(1, 7, 0); check("halt_f0", V_F0, 8'd1);
        cyc(1, 7, 0); check("halt_f1", V_F1, 8'd1);
        cyc(1, 7, 0); check("halt_f2", V_F2, 8'd1);
        cyc(1, 7, 0); check("halt_d0", V_D0, 8'd1);
        for (int i = 0; i < 4; i++) begin
            cyc(1'(i), 3'd0, 0);
            check($sformatf("halt_hold%0d", i), V_HLT, 8'd1);
        end
        pulse_reset("halt_rst");
        cyc(0, 0, 0); check("halt_cleared", V_IDLE, 8'd0);
        // Counter wrap: 255 NOPs, then a 256th
        for (int i = 0; i < 1021; i++) cyc(1, 5, 0);
        cyc(1, 6, 0); check("wrap_f0", V_F0, 8'd255);
        cyc(1, 6, 0); check("wrap_f1", V_F1, 8'd255);
        cyc(1, 6, 0); check("wrap_f2", V_F2, 8'd255);
        cyc(0, 6, 0); check("wrap_d0", V_D0, 8'd255);
        cyc(0, 6, 0); check("wrap_zero", V_IDLE, 8'd0);
        // Randomized run against the instruction-level model
        busy = 0; hlt = 0; cnt = 0; step = 0; opl = 0;
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 9) != 0;
            o = $urandom_range(0, 19) == 0 ? 3'd7 : 3'($urandom_range(0, 6));
            z = 1'($urandom_range(0, 1));
            cyc(r, o, z);
            check($sformatf("rand%0d", i), hlt ? V_HLT : !busy ? V_IDLE : mvec(step, step == 3 ? o : opl, z), cnt);
            if (!hlt && !busy) begin
                busy = r;
                step = 0;
            end else if (!hlt) begin
                if (step == 3) opl = o;
                if (step == 3 && o == 3'd7) begin
                    hlt = 1;
                    busy = 0;
                end else if (step == (opl <= 3'd3 ? 5 : 3)) begin
                    cnt++;
                    busy = r;
                    step = 0;
                end else step++;
            end
            if ((hlt && $urandom_range(0, 3) == 0) || $urandom_range(0, 199) == 0) begin
                pulse_reset($sformatf("rand_rst%0d", i));
                busy = 0; hlt = 0; cnt = 0; step = 0;
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", n, errs);
        $finish;
    end
endmodule
